// File: rtl/syscall_unit.sv
// Execute-stage syscall servicer: freezes the pipeline while it formats
// $a0 as char / hex / signed decimal and streams the bytes out over valid/ready.
module syscall_unit #(
  parameter logic [31:0] CODE_PRINT_INT  = 32'd1,
  parameter logic [31:0] CODE_EXIT       = 32'd10,
  parameter logic [31:0] CODE_PRINT_CHAR = 32'd11,
  parameter logic [31:0] CODE_PRINT_HEX  = 32'd34
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sysE,
  input  logic [31:0] regvE,
  input  logic [31:0] regaE,
  output logic        StallSys,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CONV = 3'd1;
  localparam logic [2:0] EMIT = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] HALT = 3'd4;

  logic [2:0]        state;
  // charBuf[rdIdx] is sent first; rdIdx counts down to 0 (last byte).
  logic [10:0][7:0]  charBuf;
  logic [3:0]        wrIdx, rdIdx;
  logic [4:0]        bitCnt;
  logic [31:0]       quo;
  logic [3:0]        rem;
  logic              neg;

  logic [4:0]        remSh, remDiff;
  logic              geq;
  logic [3:0]        remNxt;
  logic [31:0]       quoNxt;

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction

  // One restoring-division step by 10: quo shifts into the remainder, quotient bits shift in.
  always_comb begin
    remSh   = {rem, quo[31]};
    remDiff = remSh - 5'd10;
    geq     = (remSh >= 5'd10);
    remNxt  = geq ? remDiff[3:0] : remSh[3:0];
    quoNxt  = {quo[30:0], geq};
  end

  assign StallSys = (sysE && state != DONE) || state == HALT;
  assign tx_valid = (state == EMIT);
  assign tx_data  = tx_valid ? charBuf[rdIdx] : 8'h00;
  assign halted   = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      charBuf <= '0;
      wrIdx   <= '0;
      rdIdx   <= '0;
      bitCnt  <= '0;
      quo     <= '0;
      rem     <= '0;
      neg     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sysE) begin
          neg    <= regaE[31];
          quo    <= regaE[31] ? (~regaE + 32'd1) : regaE;
          rem    <= '0;
          bitCnt <= '0;
          wrIdx  <= '0;
          if (regvE == CODE_PRINT_CHAR) begin
            charBuf[0] <= regaE[7:0];
            rdIdx      <= 4'd0;
            state      <= EMIT;
          end else if (regvE == CODE_PRINT_HEX) begin
            for (int i = 0; i < 8; i++) charBuf[i] <= hexChar(regaE[4*i +: 4]);
            rdIdx <= 4'd7;
            state <= EMIT;
          end else if (regvE == CODE_PRINT_INT) begin
            state <= CONV;
          end else if (regvE == CODE_EXIT) begin
            state <= HALT;
          end else begin
            state <= DONE;
          end
        end
        CONV: begin
          rem    <= remNxt;
          quo    <= quoNxt;
          bitCnt <= bitCnt + 5'd1;
          // 32 steps per digit; digits land least significant first.
          if (bitCnt == 5'd31) begin
            charBuf[wrIdx] <= {4'h3, remNxt};
            wrIdx          <= wrIdx + 4'd1;
            rem            <= '0;
            if (quoNxt == 32'd0) begin
              if (neg) charBuf[wrIdx + 4'd1] <= 8'h2D;
              rdIdx <= wrIdx + {3'b000, neg};
              state <= EMIT;
            end
          end
        end
        EMIT: if (tx_ready) begin
          if (rdIdx == 4'd0) state <= DONE;
          else               rdIdx <= rdIdx - 4'd1;
        end
        DONE:    state <= IDLE;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_syscall_unit.sv
// Bench for syscall_unit: directed vector table, random calls vs a string-formatting
// reference model, exit/halt, and asynchronous reset during emission.
module tb_syscall_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sysE;
  logic [31:0] regvE, regaE;
  logic        StallSys, tx_valid, tx_ready, halted;
  logic [7:0]  tx_data;

  int checks = 0;
  int failures = 0;
  byte unsigned gotQ[$];
  int stallCnt, lowCnt;

  syscall_unit dut (
    .clk(clk), .rst_n(rst_n), .sysE(sysE), .regvE(regvE), .regaE(regaE),
    .StallSys(StallSys), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected console text computed straight from the request semantics.
  function automatic string model(input logic [31:0] v0, input logic [31:0] a0);
    case (v0)
      32'd1:   return $sformatf("%0d", $signed(a0));
      32'd34:  return $sformatf("%08h", a0);
      32'd11:  return $sformatf("%c", a0[7:0]);
      default: return "";
    endcase
  endfunction

  task automatic cmpBytes(input string name, input string exp);
    chk({name, "_len"}, gotQ.size(), exp.len());
    for (int i = 0; i < exp.len() && i < gotQ.size(); i++)
      chk({name, "_byte"}, gotQ[i], exp[i]);
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low 5 cycles on 3rd byte
  task automatic runCall(input logic [31:0] v0, input logic [31:0] a0, input int mode);
    logic held;
    logic [7:0] heldData;
    bit done;
    gotQ.delete();
    stallCnt = 0; lowCnt = 0; held = 0; heldData = 0; done = 0;
    @(negedge clk);
    sysE = 1; regvE = v0; regaE = a0; tx_ready = 0;
    #1 chk("stall_first", StallSys, 1);
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      @(negedge clk);
      if (held) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, heldData);
      end
      if (!StallSys) begin
        done = 1;
        chk("done_txv", tx_valid, 0);
        sysE = 0; tx_ready = 0;
      end else begin
        stallCnt++;
        if (tx_valid) begin
          case (mode)
            0: tx_ready = 1;
            1: tx_ready = 1'($urandom_range(0, 1));
            default: if (gotQ.size() == 2 && lowCnt < 5) begin
                       tx_ready = 0; lowCnt++;
                     end else tx_ready = 1;
          endcase
          if (tx_ready) gotQ.push_back(tx_data);
          held = !tx_ready;
          heldData = tx_data;
        end else begin
          held = 0;
          tx_ready = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!done) begin
      chk("timeout", 0, 1);
      sysE = 0;
    end
    // back in IDLE with no syscall: nothing stalled, nothing sent
    @(negedge clk);
    chk("idle_stall", StallSys, 0);
    chk("idle_txv", tx_valid, 0);
  endtask

  typedef struct {
    logic [31:0] v0;
    logic [31:0] a0;
    int          mode;
    int          expStall;
    string       exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] v0, a0;
    int sent;
    bit seen;

    vecs[0] = '{32'd11, 32'h0000_0041, 0,  1, "A"};
    vecs[1] = '{32'd1,  32'hFFFF_FECF, 0, -1, "-305"};
    vecs[2] = '{32'd1,  32'h0000_0000, 1, -1, "0"};
    vecs[3] = '{32'd1,  32'h8000_0000, 1, -1, "-2147483648"};
    vecs[4] = '{32'd1,  32'h7FFF_FFFF, 0, -1, "2147483647"};
    vecs[5] = '{32'd34, 32'h00C0_FFEE, 2, -1, "00c0ffee"};
    vecs[6] = '{32'd5,  32'h1234_5678, 0,  0, ""};

    rst_n = 0; sysE = 0; regvE = 0; regaE = 0; tx_ready = 0;
    #3;
    chk("rst_stall", StallSys, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_halt", halted, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    foreach (vecs[k]) begin
      runCall(vecs[k].v0, vecs[k].a0, vecs[k].mode);
      cmpBytes($sformatf("vec%0d", k), vecs[k].exp);
      if (vecs[k].expStall >= 0) chk($sformatf("vec%0d_stallcyc", k), stallCnt, vecs[k].expStall);
      if (vecs[k].mode == 2) chk("bp_low_cycles", lowCnt, 5);
    end

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: v0 = 32'd1;
        1: v0 = 32'd34;
        2: v0 = 32'd11;
        default: begin
          v0 = $urandom_range(0, 200);
          if (v0 == 32'd10) v0 = 32'd99;
        end
      endcase
      a0 = $urandom;
      if ($urandom_range(0, 3) == 0) a0 = a0 >> $urandom_range(0, 31);
      if (v0 == 32'd11) a0[7:0] = 8'($urandom_range(32'h20, 32'h7E));
      runCall(v0, a0, 1);
      cmpBytes($sformatf("rnd_v%0d", v0), model(v0, a0));
    end

    // exit: sticky halt, no output, sysE ignored
    @(negedge clk);
    sysE = 1; regvE = 32'd10; regaE = 32'd0; tx_ready = 1;
    repeat (100) begin
      @(negedge clk);
      chk("halt_flag", halted, 1);
      chk("halt_stall", StallSys, 1);
      chk("halt_txv", tx_valid, 0);
      sysE = 1'($urandom_range(0, 1));
      regvE = 32'd11;
    end

    // reset clears halt, then reset in the middle of "-305"
    sysE = 0; rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("halt_cleared", halted, 0);
    sysE = 1; regvE = 32'd1; regaE = 32'hFFFF_FECF; tx_ready = 1;
    sent = 0;
    for (int cyc = 0; cyc < 1000 && sent < 2; cyc++) begin
      @(negedge clk);
      if (tx_valid) sent++;
    end
    chk("pre_rst_sent", sent, 2);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", tx_valid, 1);
    rst_n = 0; sysE = 0;
    #1;
    chk("mid_rst_txv", tx_valid, 0);
    chk("mid_rst_stall", StallSys, 0);
    chk("mid_rst_halt", halted, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_valid) seen = 1;
    end
    chk("no_bytes_after_rst", seen, 0);
    runCall(32'd11, 32'h0000_005A, 0);
    cmpBytes("post_rst_char", "Z");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
